// File: rtl/uart_tx_fifo.sv
// Byte-wide write FIFO feeding an 8N1 UART transmitter, LSB first.
// Everything runs on clk; rsth is a synchronous active-high flush/reset.
module uart_tx_fifo #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int AW       = 4
) (
   input  logic          clk,
   input  logic          rsth,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic [AW:0]   fifo_cnt,
   output logic          busy,
   output logic          ovf,
   output logic          uart_tx
);

   localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CW    = $clog2(DIV);
   localparam int DEPTH = 1 << AW;
   localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          wr_acc, pop, tick;

   // A write is judged against the registered count, so a same-cycle pop cannot rescue it.
   assign full   = (cnt_q == (AW+1)'(DEPTH));
   assign wr_acc = wr_en & ~full;
   assign pop    = (state_q == IDLE) && (cnt_q != '0);
   assign tick   = (baud_q == DIV_M1);

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr_acc);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + (AW+1)'(wr_acc) - (AW+1)'(pop);
      ovf_d    = ovf_q | (wr_en & full);
   end

   always_comb begin
      state_d = state_q;
      baud_d  = tick ? '0 : baud_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: if (tick) begin
            state_d = DATA;
            bit_d   = 3'd0;
            tx_d    = shift_q[0];
         end
         DATA: if (tick) begin
            if (bit_q == 3'd7) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end else begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               tx_d    = shift_q[1];
            end
         end
         STOP: if (tick) begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rsth) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
   end

   assign fifo_cnt = cnt_q;
   assign ovf      = ovf_q;
   assign uart_tx  = tx_q;
   assign busy     = (state_q != IDLE) || (cnt_q != '0);

endmodule
